// File: rtl/plic_pkg.sv
// Shared encodings for the PLIC interrupt gateway array.
package plic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    INFL = 2'd2
  } gw_state_e;

  localparam logic MODE_EDGE  = 1'b1;
  localparam logic MODE_LEVEL = 1'b0;

  // Source ID 0 means "no source".
  localparam int ID_NONE = 0;

  // Smallest ID field width able to name every source plus ID 0.
  function automatic int id_width(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/plic_gateway_cell.sv
// One interrupt source: input synchroniser, edge history, queued-edge
// counter and the IDLE/PEND/INFL request state machine.
module plic_gateway_cell
  import plic_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_EDGE_CNT = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic edge_arm,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pend,
  output logic inflight
);

  localparam int               CNT_W   = $clog2(MAX_EDGE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_EDGE_CNT);

  logic             s;
  logic             p;
  logic             mode_q;
  gw_state_e        state_q;
  gw_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_net;
  logic             edge_trig;
  logic             trig;
  logic             edge_cnt;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = src;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= src;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // Remember last synchronised level and last mode for edge / mode-change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      p      <= 1'b0;
      mode_q <= MODE_LEVEL;
    end else begin
      p      <= s;
      mode_q <= edge_mode;
    end
  end

  // Request state and queued-edge counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; an edge arriving with a complete is counted before the
  // complete consumes it, so the source re-pends with the net count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_trig = (edge_mode == MODE_EDGE) && edge_arm && s && !p;
    trig      = (edge_mode == MODE_EDGE) ? edge_trig : s;
    edge_cnt  = edge_trig && (cnt_q != CNT_MAX);
    cnt_net   = edge_cnt ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      IDLE: begin
        if (trig) state_d = PEND;
      end
      PEND: begin
        cnt_d = cnt_net;
        if (claim_hit) state_d = INFL;
      end
      INFL: begin
        cnt_d = cnt_net;
        if (complete_hit) begin
          if ((edge_mode == MODE_EDGE) && (cnt_net != '0)) begin
            state_d = PEND;
            cnt_d   = cnt_net - CNT_W'(1);
          end else if ((edge_mode == MODE_LEVEL) && s) begin
            state_d = PEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Level mode never queues; a mode switch discards queued edges.
    if ((edge_mode == MODE_LEVEL) || (edge_mode != mode_q)) cnt_d = '0;
  end

  assign pend     = (state_q == PEND);
  assign inflight = (state_q == INFL);

endmodule

// File: rtl/plic_gateway_array.sv
// Interrupt gateway array: decodes claim/complete IDs into per-source hits
// and instantiates one gateway cell per source.
module plic_gateway_array
  import plic_pkg::*;
#(
  parameter int NUM_SRC      = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_EDGE_CNT = 7,
  parameter int ID_W         = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] edge_mode_i,
  input  logic               claim_i,
  input  logic [ID_W-1:0]    claim_id_i,
  input  logic               complete_i,
  input  logic [ID_W-1:0]    complete_id_i,
  output logic [NUM_SRC-1:0] pend_o,
  output logic [NUM_SRC-1:0] inflight_o
);

  localparam logic [ID_W-1:0]  ID_ZERO  = ID_W'(ID_NONE);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_SRC);
  localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic             claim_ok;
  logic             complete_ok;
  logic [ARM_W-1:0] arm_q;
  logic             edge_arm;

  assign claim_ok    = claim_i && (claim_id_i != ID_ZERO) && (claim_id_i <= ID_LAST);
  assign complete_ok = complete_i && (complete_id_i != ID_ZERO) && (complete_id_i <= ID_LAST);

  // After reset the synchroniser ramps up from zero; hold off edge detection
  // until the history flop holds a real sample so a line that stayed high
  // through reset is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q <= '0;
    end else if (arm_q != ARM_DONE) begin
      arm_q <= arm_q + ARM_W'(1);
    end
  end

  assign edge_arm = (arm_q == ARM_DONE);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cell
    plic_gateway_cell #(
      .SYNC_STAGES  (SYNC_STAGES),
      .MAX_EDGE_CNT (MAX_EDGE_CNT)
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .src          (src_i[g]),
      .edge_mode    (edge_mode_i[g]),
      .edge_arm     (edge_arm),
      .claim_hit    (claim_ok && (claim_id_i == ID_W'(g + 1))),
      .complete_hit (complete_ok && (complete_id_i == ID_W'(g + 1))),
      .pend         (pend_o[g]),
      .inflight     (inflight_o[g])
    );
  end

endmodule

// File: tb/tb_plic_gateway_array.sv
// Self-checking bench for plic_gateway_array: directed scenarios plus
// randomized traffic, all compared against a behavioural gateway model.
module tb_plic_gateway_array;

  localparam int N    = 8;
  localparam int SYNC = 2;
  localparam int MAXC = 7;
  localparam int IDW  = 10;
  localparam int S_IDLE = 0;
  localparam int S_PEND = 1;
  localparam int S_INFL = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src;
  logic [N-1:0]   mode;
  logic           claim;
  logic [IDW-1:0] cid;
  logic           complete;
  logic [IDW-1:0] compid;
  logic [N-1:0]   pend_o;
  logic [N-1:0]   inflight_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int           m_state [N];
  int           m_cnt   [N];
  logic [N-1:0] m_ps;
  logic [N-1:0] m_pmode;
  logic [N-1:0] m_hist [$];
  int           m_since;
  logic [N-1:0] exp_pend;
  logic [N-1:0] exp_infl;

  always #5 clk = ~clk;

  plic_gateway_array #(
    .NUM_SRC      (N),
    .SYNC_STAGES  (SYNC),
    .MAX_EDGE_CNT (MAXC),
    .ID_W         (IDW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .src_i         (src),
    .edge_mode_i   (mode),
    .claim_i       (claim),
    .claim_id_i    (cid),
    .complete_i    (complete),
    .complete_id_i (compid),
    .pend_o        (pend_o),
    .inflight_o    (inflight_o)
  );

  // One clock edge of the gateway behaviour, using the inputs present at the edge.
  task automatic model_step();
    logic [N-1:0] s;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_state[i] = S_IDLE;
        m_cnt[i]   = 0;
      end
      m_ps    = '0;
      m_pmode = '0;
      m_hist.delete();
      repeat (SYNC) m_hist.push_front('0);
      m_since = 0;
    end else begin
      m_since++;
      m_hist.push_front(src);
      s = m_hist[SYNC];
      void'(m_hist.pop_back());
      for (int i = 0; i < N; i++) begin
        bit rise, trig, c_hit, f_hit;
        int net;
        // a rise needs two genuine post-reset samples of the line
        rise  = mode[i] && s[i] && !m_ps[i] && (m_since > SYNC + 1);
        trig  = mode[i] ? rise : s[i];
        c_hit = claim && (int'(cid) == i + 1);
        f_hit = complete && (int'(compid) == i + 1);
        net   = (rise && m_cnt[i] < MAXC) ? m_cnt[i] + 1 : m_cnt[i];
        case (m_state[i])
          S_IDLE: if (trig) m_state[i] = S_PEND;
          S_PEND: begin
            m_cnt[i] = net;
            if (c_hit) m_state[i] = S_INFL;
          end
          default: begin
            m_cnt[i] = net;
            if (f_hit) begin
              if (mode[i] && net > 0) begin
                m_state[i] = S_PEND;
                m_cnt[i]   = net - 1;
              end else if (!mode[i] && s[i]) begin
                m_state[i] = S_PEND;
              end else begin
                m_state[i] = S_IDLE;
              end
            end
          end
        endcase
        if (!mode[i] || (mode[i] != m_pmode[i])) m_cnt[i] = 0;
      end
      m_ps    = s;
      m_pmode = mode;
    end
    for (int i = 0; i < N; i++) begin
      exp_pend[i] = (m_state[i] == S_PEND);
      exp_infl[i] = (m_state[i] == S_INFL);
    end
  endtask

  // Advance one clock; outputs are settled 1ns after the edge. Strobes are one cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    claim    = 1'b0;
    complete = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; src = '0; mode = 8'hFD;
    claim = 1'b0; cid = '0; complete = 1'b0; compid = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (pend_o !== '0 || inflight_o !== '0) begin
      errors++;
      $display("FAIL reset_state: pend=%h infl=%h, expected 00/00", pend_o, inflight_o);
    end
    repeat (4) begin
      tick();
      checks++;
      if (pend_o !== exp_pend || inflight_o !== exp_infl) begin
        errors++;
        $display("FAIL reset_idle: pend=%h infl=%h, expected %h/%h", pend_o, inflight_o, exp_pend, exp_infl);
      end
    end
  endtask

  task automatic test_edge_basic();
    src[2] = 1'b1; tick(); src[2] = 1'b0;
    tick();
    checks++;
    if (pend_o[2] !== 1'b0) begin
      errors++; $display("FAIL edge_latency_early: pend[2]=%b, expected 0", pend_o[2]);
    end
    tick();
    checks++;
    if (pend_o[2] !== 1'b1) begin
      errors++; $display("FAIL edge_latency: pend[2]=%b, expected 1", pend_o[2]);
    end
    claim = 1'b1; cid = 10'd3; tick();
    checks++;
    if (inflight_o[2] !== 1'b1 || pend_o[2] !== 1'b0) begin
      errors++; $display("FAIL edge_claim: pend[2]=%b infl[2]=%b, expected 0/1", pend_o[2], inflight_o[2]);
    end
    complete = 1'b1; compid = 10'd3; tick();
    checks++;
    if (pend_o !== exp_pend || inflight_o !== exp_infl || pend_o[2] !== 1'b0 || inflight_o[2] !== 1'b0) begin
      errors++; $display("FAIL edge_complete: pend=%h infl=%h, expected %h/%h", pend_o, inflight_o, exp_pend, exp_infl);
    end
  endtask

  task automatic test_edge_queue();
    src[0] = 1'b1; tick(); src[0] = 1'b0; repeat (2) tick();
    claim = 1'b1; cid = 10'd1; tick();
    repeat (3) begin
      src[0] = 1'b1; tick(); src[0] = 1'b0; tick();
    end
    repeat (3) tick();
    checks++;
    if (inflight_o[0] !== 1'b1 || pend_o[0] !== 1'b0) begin
      errors++; $display("FAIL queue_infl: pend[0]=%b infl[0]=%b, expected 0/1", pend_o[0], inflight_o[0]);
    end
    for (int r = 0; r < 3; r++) begin
      complete = 1'b1; compid = 10'd1; tick();
      checks++;
      if (pend_o[0] !== 1'b1 || inflight_o[0] !== 1'b0) begin
        errors++; $display("FAIL queue_repend %0d: pend[0]=%b infl[0]=%b, expected 1/0", r, pend_o[0], inflight_o[0]);
      end
      claim = 1'b1; cid = 10'd1; tick();
      checks++;
      if (pend_o !== exp_pend || inflight_o !== exp_infl) begin
        errors++; $display("FAIL queue_reclaim %0d: pend=%h infl=%h, expected %h/%h", r, pend_o, inflight_o, exp_pend, exp_infl);
      end
    end
    complete = 1'b1; compid = 10'd1; tick();
    repeat (4) tick();
    checks++;
    if (pend_o[0] !== 1'b0 || inflight_o[0] !== 1'b0) begin
      errors++; $display("FAIL queue_drain: pend[0]=%b infl[0]=%b, expected 0/0", pend_o[0], inflight_o[0]);
    end
  endtask

  task automatic test_saturation();
    int reissue;
    reissue = 0;
    src[0] = 1'b1; tick(); src[0] = 1'b0; repeat (2) tick();
    claim = 1'b1; cid = 10'd1; tick();
    repeat (10) begin
      src[0] = 1'b1; tick(); src[0] = 1'b0; tick();
    end
    repeat (3) tick();
    for (int r = 0; r < 12; r++) begin
      complete = 1'b1; compid = 10'd1; tick();
      if (pend_o[0] !== 1'b1) break;
      reissue++;
      claim = 1'b1; cid = 10'd1; tick();
    end
    checks++;
    if (reissue != MAXC) begin
      errors++; $display("FAIL saturation_count: reissues=%0d, expected %0d", reissue, MAXC);
    end
    checks++;
    if (pend_o !== exp_pend || inflight_o !== exp_infl || pend_o[0] !== 1'b0 || inflight_o[0] !== 1'b0) begin
      errors++; $display("FAIL saturation_idle: pend=%h infl=%h, expected %h/%h", pend_o, inflight_o, exp_pend, exp_infl);
    end
  endtask

  task automatic test_level();
    src[1] = 1'b1; repeat (3) tick();
    checks++;
    if (pend_o[1] !== 1'b1) begin
      errors++; $display("FAIL level_pend: pend[1]=%b, expected 1", pend_o[1]);
    end
    claim = 1'b1; cid = 10'd2; tick();
    complete = 1'b1; compid = 10'd2; tick();
    checks++;
    if (pend_o[1] !== 1'b1 || inflight_o[1] !== 1'b0) begin
      errors++; $display("FAIL level_repend: pend[1]=%b infl[1]=%b, expected 1/0", pend_o[1], inflight_o[1]);
    end
    claim = 1'b1; cid = 10'd2; tick();
    src[1] = 1'b0; repeat (3) tick();
    complete = 1'b1; compid = 10'd2; tick();
    checks++;
    if (pend_o[1] !== 1'b0 || inflight_o[1] !== 1'b0) begin
      errors++; $display("FAIL level_drop: pend[1]=%b infl[1]=%b, expected 0/0", pend_o[1], inflight_o[1]);
    end
    src[1] = 1'b1; repeat (3) tick();
    src[1] = 1'b0; repeat (4) tick();
    checks++;
    if (pend_o[1] !== 1'b1) begin
      errors++; $display("FAIL level_no_retract: pend[1]=%b, expected 1", pend_o[1]);
    end
    claim = 1'b1; cid = 10'd2; tick();
    complete = 1'b1; compid = 10'd2; tick();
    checks++;
    if (pend_o !== exp_pend || inflight_o !== exp_infl) begin
      errors++; $display("FAIL level_final: pend=%h infl=%h, expected %h/%h", pend_o, inflight_o, exp_pend, exp_infl);
    end
  endtask

  task automatic test_corner_ids();
    src[4] = 1'b1; src[3] = 1'b1; tick();
    src[4] = 1'b0; src[3] = 1'b0; repeat (2) tick();
    claim = 1'b1; cid = 10'd4; tick();
    claim = 1'b1; cid = 10'd0; tick();
    claim = 1'b1; cid = 10'(N + 1); tick();
    complete = 1'b1; compid = 10'd0; tick();
    complete = 1'b1; compid = 10'd1023; tick();
    checks++;
    if (pend_o[4] !== 1'b1 || inflight_o[3] !== 1'b1 || pend_o !== exp_pend || inflight_o !== exp_infl) begin
      errors++; $display("FAIL bad_id_ignored: pend=%h infl=%h, expected %h/%h", pend_o, inflight_o, exp_pend, exp_infl);
    end
    complete = 1'b1; compid = 10'd5; tick();
    checks++;
    if (pend_o[4] !== 1'b1 || inflight_o[4] !== 1'b0) begin
      errors++; $display("FAIL complete_in_pend: pend[4]=%b infl[4]=%b, expected 1/0", pend_o[4], inflight_o[4]);
    end
    claim = 1'b1; cid = 10'd4; complete = 1'b1; compid = 10'd4; tick();
    checks++;
    if (pend_o[3] !== 1'b0 || inflight_o[3] !== 1'b0) begin
      errors++; $display("FAIL claim_complete_infl: pend[3]=%b infl[3]=%b, expected 0/0", pend_o[3], inflight_o[3]);
    end
    claim = 1'b1; cid = 10'd5; complete = 1'b1; compid = 10'd5; tick();
    checks++;
    if (pend_o[4] !== 1'b0 || inflight_o[4] !== 1'b1) begin
      errors++; $display("FAIL claim_complete_pend: pend[4]=%b infl[4]=%b, expected 0/1", pend_o[4], inflight_o[4]);
    end
    complete = 1'b1; compid = 10'd5; tick();
    checks++;
    if (pend_o !== exp_pend || inflight_o !== exp_infl || inflight_o[4] !== 1'b0) begin
      errors++; $display("FAIL corner_final: pend=%h infl=%h, expected %h/%h", pend_o, inflight_o, exp_pend, exp_infl);
    end
  endtask

  task automatic test_reset_mid();
    src[0] = 1'b1; tick(); src[0] = 1'b0; repeat (2) tick();
    claim = 1'b1; cid = 10'd1; tick();
    src[0] = 1'b1; tick(); src[0] = 1'b0; tick();
    src[0] = 1'b1; tick(); src[0] = 1'b0;
    src[4] = 1'b1; src[1] = 1'b1; src[6] = 1'b1; tick();
    src[4] = 1'b0; repeat (4) tick();
    checks++;
    if ({inflight_o[0], pend_o[6], pend_o[4], pend_o[1]} !== 4'hF) begin
      errors++; $display("FAIL reset_mid_setup: pend=%h infl=%h, expected pend bits 1,4,6 and infl bit 0", pend_o, inflight_o);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (pend_o !== '0 || inflight_o !== '0) begin
      errors++; $display("FAIL reset_mid_clear: pend=%h infl=%h, expected 00/00", pend_o, inflight_o);
    end
    tick(); tick();
    checks++;
    if (pend_o[1] !== 1'b0) begin
      errors++; $display("FAIL reset_level_early: pend[1]=%b, expected 0", pend_o[1]);
    end
    tick();
    checks++;
    if (pend_o[1] !== 1'b1 || pend_o[6] !== 1'b0) begin
      errors++; $display("FAIL reset_level_repend: pend[1]=%b pend[6]=%b, expected 1/0", pend_o[1], pend_o[6]);
    end
    repeat (6) tick();
    checks++;
    if (pend_o[6] !== 1'b0 || pend_o[0] !== 1'b0 || inflight_o !== '0 || pend_o !== exp_pend) begin
      errors++; $display("FAIL reset_edge_held: pend=%h infl=%h, expected %h/00", pend_o, inflight_o, exp_pend);
    end
    src = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      src = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 31) == 0) mode = N'($urandom);
      claim    = ($urandom_range(0, 2) == 0);
      cid      = IDW'($urandom_range(0, 10));
      complete = ($urandom_range(0, 2) == 0);
      compid   = IDW'($urandom_range(0, 10));
      rst      = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if (pend_o !== exp_pend || inflight_o !== exp_infl) begin
        errors++;
        $display("FAIL random cycle %0d: pend=%h infl=%h, expected %h/%h", c, pend_o, inflight_o, exp_pend, exp_infl);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_edge_queue();
    test_saturation();
    test_level();
    test_corner_ids();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plic_gateway_array.md
Name: plic_gateway_array

Overview:
- Multi-source interrupt gateway between external interrupt lines and the PLIC priority/claim logic.
- Per source: optional input synchronisation, runtime-selectable edge or level mode, and a pending/in-flight state machine.
- Edge mode adds a saturating counter so edges arriving while a request is pending or in flight are re-issued, not lost.
- Drives one pending bit per source into the PLIC arbiter; consumes that arbiter's claim and complete strobes.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..1023); source IDs are 1..NUM_SRC, ID 0 is reserved for "none".
- SYNC_STAGES, 2, flops in the input synchroniser (0..3); 0 means src_i is already in the clk domain.
- MAX_EDGE_CNT, 7, saturation value of the per-source queued-edge counter (1..255).
- ID_W, 10, width of the claim/complete ID fields; must satisfy 2^ID_W > NUM_SRC.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- src_i  in  NUM_SRC  raw interrupt lines; bit i is source ID i+1.
- edge_mode_i  in  NUM_SRC  per-source mode, from the PLIC config register: 1 = rising-edge, 0 = level-high.
- claim_i  in  1  claim strobe, one cycle.
- claim_id_i  in  ID_W  ID being claimed.
- complete_i  in  1  complete strobe, one cycle.
- complete_id_i  in  ID_W  ID being completed.
- pend_o  out  NUM_SRC  registered pending bits to the arbiter.
- inflight_o  out  NUM_SRC  registered in-flight (claimed, not yet completed) bits.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE for all sources; synchroniser flops, edge-history flops and counters cleared; pend_o = 0, inflight_o = 0.
- Synchroniser output s: src_i delayed by SYNC_STAGES flops.
- History flop p <= s every cycle.
- Trigger:
  - Edge mode: trig = s & ~p.
  - Level mode: trig = s.
- States per source (2-bit encoding): IDLE = 0, PEND = 1, INFL = 2.
- IDLE:
  - trig -> PEND.
  - complete for this ID -> ignored.
- PEND:
  - claim_i with claim_id_i == ID -> INFL.
  - Edge-mode trig -> cnt++ (saturating).
  - complete -> ignored.
- INFL, on complete_i with complete_id_i == ID:
  - Edge mode with cnt > 0 -> PEND, cnt--.
  - Level mode with s == 1 -> PEND.
  - Otherwise -> IDLE.
- INFL, other events:
  - Edge-mode trig -> cnt++ (saturating).
  - Claim -> ignored.
- Simultaneous edge and complete in INFL: the edge is counted first, so the source goes to PEND with the net cnt. Example: cnt 0 + edge + complete -> PEND, cnt 0.
- Simultaneous claim and complete for the same ID:
  - In INFL: complete applies, claim is ignored.
  - In PEND: claim applies.
- Saturation: cnt stops at MAX_EDGE_CNT; further edges are dropped silently.
- Level mode keeps cnt at 0. Any change of edge_mode_i clears cnt in the same cycle; the state is unchanged.
- Level mode, PEND: stays PEND even if s drops before claim (no retraction).
- Out-of-range IDs: ID 0 or ID > NUM_SRC on claim/complete is ignored by all sources.
- Outputs: pend_o = (state == PEND); inflight_o = (state == INFL). Both come straight from state flops, with no combinational path from inputs.
- Latency: a rising src_i first sampled at edge k gives pend_o high after edge k + SYNC_STAGES. With SYNC_STAGES = 0, pend_o rises at the same clock edge that samples src_i.
- Claim at edge k: pend_o low and inflight_o high after edge k.
- Reset mid-operation: all pending, in-flight and counted edges are discarded. Edge mode: a line held high through reset produces no trigger (p is cleared and s ramps). Level mode: that line re-pends after SYNC_STAGES + 1 edges.

Decomposition:
- Package plic_pkg:
  - state encoding constants (IDLE, PEND, INFL);
  - mode constants (EDGE = 1, LEVEL = 0);
  - ID 0 "none" constant;
  - ID width function (clog2(NUM_SRC + 1)).
- Sub-module plic_gateway_cell:
  - holds one source's synchroniser, history flop, counter and FSM;
  - takes the decoded per-source claim/complete hits.
- plic_gateway_array: generates NUM_SRC cells and does ID decoding (range check plus one-hot compare).

Test Plan:
- Edge mode, SYNC_STAGES = 2:
  - 1-cycle pulse on src_i[2] -> pend_o[2] high after 2 edges;
  - claim ID 3 -> inflight_o[2] = 1, pend_o[2] = 0;
  - complete ID 3 -> IDLE.
- Edge mode, queued edges:
  - while ID 1 in INFL, 3 pulses on src_i[0] -> cnt = 3;
  - each complete/claim pair re-pends;
  - after the 4th complete -> IDLE, pend_o[0] stays 0.
- Edge mode, saturation with MAX_EDGE_CNT = 7: 10 pulses while INFL -> exactly 7 re-issues, then IDLE.
- Level mode:
  - src_i[1] held high through claim and complete of ID 2 -> back to PEND one cycle after complete;
  - src_i[1] dropped before complete -> IDLE.
- Corner IDs:
  - claim ID 0 and ID NUM_SRC + 1 -> no state change anywhere;
  - complete ID 5 while source 5 is PEND -> ignored;
  - same-cycle claim + complete ID 4 while INFL -> complete wins.
- Reset:
  - assert rst for 1 cycle with 3 sources PEND/INFL and cnt > 0 -> all outputs 0 next cycle;
  - edge-mode line held high -> no re-pend;
  - level-mode line held high -> re-pends after SYNC_STAGES + 1 edges.
